// File: rtl/acc_seq_unit_if.sv
// Request/result bundle between the ALU sequencer and the accumulator stage.
// Handshake: START is sampled only while BUSY=0; DONE pulses for one cycle per completed op.
interface acc_seq_unit_if #(
   parameter int WIDTH = 4
);
   logic [1:0]       i_op;
   logic [WIDTH-1:0] i_operand;
   logic             i_start;
   logic             o_busy;
   logic             o_done;
   logic [WIDTH-1:0] o_acc;
   logic [WIDTH-1:0] o_product_hi;
   logic             o_carry;
   logic             o_zero;

   modport master (
      output i_op, i_operand, i_start,
      input  o_busy, o_done, o_acc, o_product_hi, o_carry, o_zero
   );

   modport slave (
      input  i_op, i_operand, i_start,
      output o_busy, o_done, o_acc, o_product_hi, o_carry, o_zero
   );
endinterface

// File: rtl/acc_seq_unit.sv
// Accumulator with CARRY/ZERO flags, add-with-carry chaining and an iterative
// shift-add multiplier that reuses a single WIDTH-bit adder.
module acc_seq_unit #(
   parameter int WIDTH = 4
) (
   input  logic          i_clk,
   input  logic          i_reset,
   acc_seq_unit_if.slave bus,
   output logic          o_dbg_state
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_ADD  = 2'b01;
   localparam logic [1:0] OP_ADC  = 2'b10;
   localparam logic [1:0] OP_MUL  = 2'b11;

   typedef enum logic {S_IDLE, S_MUL_RUN} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_product_hi;
   logic             r_carry;
   logic             r_zero;
   logic             r_done;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [WIDTH-1:0] r_phi;
   logic [CW-1:0]    r_cnt;

   state_t           w_next_state;
   logic             w_accept;
   logic             w_last;
   logic             w_cin;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_step;
   logic [WIDTH-1:0] w_phi_nxt;
   logic [WIDTH-1:0] w_mplier_nxt;

   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_last       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.i_start) begin
               w_accept = 1'b1;
               if (bus.i_op == OP_MUL) w_next_state = S_MUL_RUN;
            end
         end
         S_MUL_RUN: begin
            if (r_cnt == CW'(WIDTH - 1)) begin
               w_last       = 1'b1;
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase

      w_cin = (bus.i_op == OP_ADC) ? r_carry : 1'b0;
      w_sum = {1'b0, r_acc} + {1'b0, bus.i_operand} + {{WIDTH{1'b0}}, w_cin};

      // One multiply step: conditional add, then shift {c,hi,multiplier} right by one.
      w_step       = r_mplier[0] ? ({1'b0, r_phi} + {1'b0, r_mcand}) : {1'b0, r_phi};
      w_phi_nxt    = w_step[WIDTH:1];
      w_mplier_nxt = {w_step[0], r_mplier[WIDTH-1:1]};
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_acc        <= '0;
         r_product_hi <= '0;
         r_carry      <= 1'b0;
         r_zero       <= 1'b0;
         r_done       <= 1'b0;
         r_mcand      <= '0;
         r_mplier     <= '0;
         r_phi        <= '0;
         r_cnt        <= '0;
      end else begin
         r_state <= w_next_state;
         r_done  <= 1'b0;
         if (w_accept) begin
            case (bus.i_op)
               OP_LOAD: begin
                  r_acc        <= bus.i_operand;
                  r_product_hi <= '0;
                  r_zero       <= (bus.i_operand == '0);
                  r_done       <= 1'b1;
               end
               OP_ADD, OP_ADC: begin
                  {r_carry, r_acc} <= w_sum;
                  r_product_hi     <= '0;
                  r_zero           <= (w_sum[WIDTH-1:0] == '0);
                  r_done           <= 1'b1;
               end
               default: begin
                  r_mcand  <= r_acc;
                  r_mplier <= bus.i_operand;
                  r_phi    <= '0;
                  r_cnt    <= '0;
               end
            endcase
         end
         if (r_state == S_MUL_RUN) begin
            r_phi    <= w_phi_nxt;
            r_mplier <= w_mplier_nxt;
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
               r_product_hi <= w_phi_nxt;
               r_acc        <= w_mplier_nxt;
               r_carry      <= 1'b0;
               r_zero       <= ({w_phi_nxt, w_mplier_nxt} == '0);
               r_done       <= 1'b1;
            end
         end
      end
   end

   assign bus.o_busy       = (r_state == S_MUL_RUN);
   assign bus.o_done       = r_done;
   assign bus.o_acc        = r_acc;
   assign bus.o_product_hi = r_product_hi;
   assign bus.o_carry      = r_carry;
   assign bus.o_zero       = r_zero;
   assign o_dbg_state      = r_state;
endmodule

// File: tb/tb_acc_seq_unit.sv
// Directed plus randomized checking of acc_seq_unit against an arithmetic reference model.
module tb_acc_seq_unit;
   localparam int W = 4;
   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_ADD  = 2'b01;
   localparam logic [1:0] OP_ADC  = 2'b10;
   localparam logic [1:0] OP_MUL  = 2'b11;

   logic clk = 1'b0;
   logic reset;
   logic dbg_state;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_fail   = 0;

   int m_acc, m_hi, m_carry, m_zero;

   acc_seq_unit_if #(.WIDTH(W)) bus ();

   acc_seq_unit #(.WIDTH(W)) dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_acc = 0; m_hi = 0; m_carry = 0; m_zero = 0;
   endtask

   task automatic model_apply(input logic [1:0] op, input int val);
      int s, p;
      case (op)
         OP_LOAD: begin
            m_acc = val; m_hi = 0; m_zero = (val == 0);
         end
         OP_ADD, OP_ADC: begin
            s = m_acc + val + ((op == OP_ADC) ? m_carry : 0);
            m_carry = s / 16; m_acc = s % 16; m_hi = 0; m_zero = (m_acc == 0);
         end
         default: begin
            p = m_acc * val;
            m_hi = p / 16; m_acc = p % 16; m_carry = 0; m_zero = (p == 0);
         end
      endcase
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_acc"},   32'(bus.o_acc),        32'(m_acc));
      check({tag, "_hi"},    32'(bus.o_product_hi), 32'(m_hi));
      check({tag, "_carry"}, 32'(bus.o_carry),      32'(m_carry));
      check({tag, "_zero"},  32'(bus.o_zero),       32'(m_zero));
   endtask

   // Issue one op, optionally pulse a spurious LOAD 3 request while the multiply runs.
   task automatic run_op(input logic [1:0] op, input int val, input bit intrude);
      int k, busy_cycles, dones_after;
      bit got;
      @(negedge clk);
      bus.i_op = op; bus.i_operand = W'(val); bus.i_start = 1'b1;
      @(negedge clk);
      bus.i_start = 1'b0;
      k = 1; busy_cycles = 0; got = 1'b0;
      while (k <= 20 && !got) begin
         if (bus.o_done) got = 1'b1;
         else begin
            if (bus.o_busy) busy_cycles++;
            if (intrude && k == 2) begin
               bus.i_start = 1'b1; bus.i_op = OP_LOAD; bus.i_operand = 4'd3;
            end
            if (intrude && k == 3) bus.i_start = 1'b0;
            @(negedge clk);
            k++;
         end
      end
      model_apply(op, val);
      check("done_seen", 32'(got), 32'd1);
      check("latency", 32'(k), (op == OP_MUL) ? 32'd5 : 32'd1);
      check("busy_cycles", 32'(busy_cycles), (op == OP_MUL) ? 32'd4 : 32'd0);
      check("busy_at_done", 32'(bus.o_busy), 32'd0);
      check_outputs("result");
      dones_after = 0;
      for (int i = 0; i < (intrude ? 4 : 1); i++) begin
         @(negedge clk);
         if (bus.o_done) dones_after++;
      end
      check("done_single_pulse", 32'(dones_after), 32'd0);
   endtask

   initial begin
      int dones;
      reset = 1'b1;
      bus.i_op = 2'($urandom_range(0, 3));
      bus.i_operand = 4'($urandom_range(0, 15));
      bus.i_start = 1'($urandom_range(0, 1));
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_outputs("reset");
      check("reset_busy", 32'(bus.o_busy), 32'd0);
      check("reset_done", 32'(bus.o_done), 32'd0);
      bus.i_start = 1'b0;
      reset = 1'b0;

      run_op(OP_LOAD, 9, 1'b0);
      run_op(OP_ADD, 9, 1'b0);
      check("add9_acc", 32'(bus.o_acc), 32'd2);
      check("add9_carry", 32'(bus.o_carry), 32'd1);
      run_op(OP_ADC, 13, 1'b0);
      check("adc13_acc", 32'(bus.o_acc), 32'd0);
      check("adc13_zero", 32'(bus.o_zero), 32'd1);
      check("adc13_carry", 32'(bus.o_carry), 32'd1);

      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            run_op(OP_LOAD, a, 1'b0);
            run_op(OP_ADD, b, 1'b0);
            check("add_exh", {27'd0, bus.o_carry, bus.o_acc}, 32'(a + b));
         end
      end

      run_op(OP_LOAD, 15, 1'b0);
      run_op(OP_MUL, 15, 1'b0);
      check("mul_ff_hi", 32'(bus.o_product_hi), 32'hE);
      check("mul_ff_lo", 32'(bus.o_acc), 32'h1);
      run_op(OP_LOAD, 0, 1'b0);
      run_op(OP_MUL, 7, 1'b0);
      check("mul_zero_flag", 32'(bus.o_zero), 32'd1);

      run_op(OP_LOAD, 11, 1'b0);
      run_op(OP_MUL, 13, 1'b1);

      // Abort a multiply with reset during its second run cycle.
      run_op(OP_LOAD, 5, 1'b0);
      @(negedge clk);
      bus.i_op = OP_MUL; bus.i_operand = 4'd6; bus.i_start = 1'b1;
      @(negedge clk);
      bus.i_start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      check_outputs("abort");
      check("abort_busy", 32'(bus.o_busy), 32'd0);
      check("abort_done", 32'(bus.o_done), 32'd0);
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.o_done) dones++;
      end
      check("abort_no_done", 32'(dones), 32'd0);
      run_op(OP_ADD, 7, 1'b0);

      for (int i = 0; i < 300; i++) begin
         run_op(2'($urandom_range(0, 3)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
